// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side drain stage.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int OUT_BUF_DEPTH  = 2;

   typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer: capture at wr_ptr, present head at rd_ptr, wrapping 1-bit pointers.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  cap,
   input  logic [DATA_WIDTH-1:0] cap_data,
   input  logic                  pop,
   output occ_t                  count,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem [OUT_BUF_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < OUT_BUF_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (cap) begin
            mem[wr_ptr] <= cap_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({cap, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

   // When full the pointers coincide, so a capture is only safe if the head leaves on the same edge.
   a_no_overflow: assert property (@(posedge clk) disable iff (areset)
      !(cap && !pop && (count == 2'd2)));

endmodule

// File: rtl/fifo_stream_out.sv
// FIFO read-side drain: converts empty/read into a valid/ready stream through a 2-entry buffer.
// Optional beat/stall statistics counters are built when STREAM_STATS_EN is defined.
module fifo_stream_out
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
`ifdef STREAM_STATS_EN
   ,
   output logic [15:0]           beat_cnt,
   output logic [15:0]           stall_cnt
`endif
);

   occ_t count;
   occ_t occ;
   logic inflight;
   logic cap;
   logic pop;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   assign occ       = count + {1'b0, inflight};
   // A pop frees a slot this edge, so a read may be issued even at full credit.
   assign fifo_rd   = ~fifo_empty & ((occ < 2'd2) | pop);

   generate
      if (RD_LATENCY == 0) begin : g_lat0
         assign inflight = 1'b0;
         assign cap      = fifo_rd;
      end else begin : g_lat1
         always_ff @(posedge clk or posedge areset) begin
            if (areset) inflight <= 1'b0;
            else        inflight <= fifo_rd;
         end
         assign cap = inflight;
      end
   endgenerate

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .areset    (areset),
      .cap       (cap),
      .cap_data  (fifo_rdata),
      .pop       (pop),
      .count     (count),
      .head_data (out_data)
   );

`ifdef STREAM_STATS_EN
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop && (beat_cnt != 16'hFFFF))
            beat_cnt <= beat_cnt + 16'd1;
         if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: one DUT at RD_LATENCY=0 and one at RD_LATENCY=1, fed by a shared FIFO model.
module tb_fifo_stream_out;

   logic       clk = 1'b0;
   logic       areset;
   logic       out_ready;
   logic       empty0, empty1, rd0, rd1, valid0, valid1;
   logic [7:0] rdata0, rdata1, data0, data1;
`ifdef STREAM_STATS_EN
   logic [15:0] beat0, beat1, stall0, stall1;
`endif

   always #5 clk = ~clk;

   fifo_stream_out #(.DATA_WIDTH(8), .RD_LATENCY(0)) u_l0 (
      .clk(clk), .areset(areset), .fifo_empty(empty0), .fifo_rd(rd0), .fifo_rdata(rdata0),
      .out_valid(valid0), .out_ready(out_ready), .out_data(data0)
`ifdef STREAM_STATS_EN
      , .beat_cnt(beat0), .stall_cnt(stall0)
`endif
   );

   fifo_stream_out #(.DATA_WIDTH(8), .RD_LATENCY(1)) u_l1 (
      .clk(clk), .areset(areset), .fifo_empty(empty1), .fifo_rd(rd1), .fifo_rdata(rdata1),
      .out_valid(valid1), .out_ready(out_ready), .out_data(data1)
`ifdef STREAM_STATS_EN
      , .beat_cnt(beat1), .stall_cnt(stall1)
`endif
   );

   // FIFO model: shared storage and write pointer, one read pointer per consumer
   logic [7:0] mem [256];
   logic [7:0] wp, rp0, rp1, rq1;

   assign empty0 = (rp0 == wp);
   assign empty1 = (rp1 == wp);
   assign rdata0 = mem[rp0];
   assign rdata1 = rq1;

   always @(posedge clk or posedge areset) begin
      if (areset) begin
         rp0 <= '0;
         rp1 <= '0;
         rq1 <= '0;
      end else begin
         if (rd0) rp0 <= rp0 + 8'd1;
         if (rd1) begin
            rp1 <= rp1 + 8'd1;
            rq1 <= mem[rp1];
         end
      end
   end

   typedef struct packed {
      logic       ready;
      logic       v0;
      logic [7:0] d0;
      logic       r0;
      logic       v1;
      logic [7:0] d1;
      logic       r1;
   } vec_t;

   vec_t vt [17];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic vec_t mk(logic ready, logic v0, logic [7:0] d0, logic r0,
                               logic v1, logic [7:0] d1, logic r1);
      vec_t v;
      v.ready = ready; v.v0 = v0; v.d0 = d0; v.r0 = r0;
      v.v1 = v1; v.d1 = d1; v.r1 = r1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [7:0] w);
      mem[wp] = w;
      wp = wp + 8'd1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      areset    = 1'b1;
      out_ready = 1'b0;
      wp        = '0;
      repeat (2) @(negedge clk);
      areset = 1'b0;
   endtask

   task automatic idle(input int n);
      out_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic run_rows(input int lo, input int hi, input logic [7:0] w0,
                           input logic [7:0] step, input int n);
      for (int k = lo; k <= hi; k++) begin
         @(negedge clk);
         if (k == lo)
            for (int j = 0; j < n; j++) push(w0 + step * 8'(j));
         out_ready = vt[k].ready;
         #1;
         chk($sformatf("row%0d_valid_l0", k), valid0, vt[k].v0);
         chk($sformatf("row%0d_rd_l0", k),    rd0,    vt[k].r0);
         if (vt[k].v0) chk($sformatf("row%0d_data_l0", k), data0, vt[k].d0);
         chk($sformatf("row%0d_valid_l1", k), valid1, vt[k].v1);
         chk($sformatf("row%0d_rd_l1", k),    rd1,    vt[k].r1);
         if (vt[k].v1) chk($sformatf("row%0d_data_l1", k), data1, vt[k].d1);
      end
   endtask

   initial begin
      logic [7:0] ep0, ep1, got0, got1;
      int         pushed, bad, cyc;

      // Three words, ready high: back-to-back beats
      vt[0]  = mk(1, 0, 8'h00, 1,  0, 8'h00, 1);
      vt[1]  = mk(1, 1, 8'h11, 1,  0, 8'h00, 1);
      vt[2]  = mk(1, 1, 8'h22, 1,  1, 8'h11, 1);
      vt[3]  = mk(1, 1, 8'h33, 0,  1, 8'h22, 0);
      vt[4]  = mk(1, 0, 8'h00, 0,  1, 8'h33, 0);
      vt[5]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 0);
      // Five words, ready low then released
      vt[6]  = mk(0, 0, 8'h00, 1,  0, 8'h00, 1);
      vt[7]  = mk(0, 1, 8'hA0, 1,  0, 8'h00, 1);
      vt[8]  = mk(0, 1, 8'hA0, 0,  1, 8'hA0, 0);
      vt[9]  = mk(0, 1, 8'hA0, 0,  1, 8'hA0, 0);
      vt[10] = mk(0, 1, 8'hA0, 0,  1, 8'hA0, 0);
      vt[11] = mk(1, 1, 8'hA0, 1,  1, 8'hA0, 1);
      vt[12] = mk(1, 1, 8'hA1, 1,  1, 8'hA1, 1);
      vt[13] = mk(1, 1, 8'hA2, 1,  1, 8'hA2, 1);
      vt[14] = mk(1, 1, 8'hA3, 0,  1, 8'hA3, 0);
      vt[15] = mk(1, 1, 8'hA4, 0,  1, 8'hA4, 0);
      vt[16] = mk(1, 0, 8'h00, 0,  0, 8'h00, 0);

      areset    = 1'b1;
      out_ready = 1'b0;
      wp        = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      areset = 1'b0;
      #1;
      chk("reset_valid_l0", valid0, 0);
      chk("reset_data_l0",  data0,  0);
      chk("reset_rd_l0",    rd0,    0);
      chk("reset_valid_l1", valid1, 0);
      chk("reset_data_l1",  data1,  0);
      chk("reset_rd_l1",    rd1,    0);

      run_rows(0, 5, 8'h11, 8'h11, 3);
      run_rows(6, 16, 8'hA0, 8'h01, 5);

      // Single word; the next one arrives in the cycle it pops (L0 aligned)
      idle(3);
      @(negedge clk); push(8'hC1); #1;
      @(negedge clk); push(8'hC2); #1;
      chk("t6a_pop_data_l0", data0, 8'hC1);
      chk("t6a_rd_l0", rd0, 1);
      @(negedge clk); #1;
      chk("t6a_next_valid_l0", valid0, 1);
      chk("t6a_next_data_l0", data0, 8'hC2);
      idle(6);
      // Same scenario aligned to the L1 pop
      @(negedge clk); push(8'hD1);
      @(negedge clk);
      @(negedge clk); push(8'hD2); #1;
      chk("t6b_pop_data_l1", data1, 8'hD1);
      chk("t6b_pop_valid_l1", valid1, 1);
      chk("t6b_rd_l1", rd1, 1);
      @(negedge clk); #1;
      chk("t6b_bubble_l1", valid1, 0);
      @(negedge clk); #1;
      chk("t6b_next_valid_l1", valid1, 1);
      chk("t6b_next_data_l1", data1, 8'hD2);
      idle(6);

      // Random ready, 200 random words, scoreboard against the model storage
      ep0 = wp; ep1 = wp; pushed = 0; bad = 0; cyc = 0;
      while ((pushed < 200 || ep0 != wp || ep1 != wp) && cyc < 3000) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         if (pushed < 200 && $urandom_range(0, 2) != 0) begin
            push(8'($urandom));
            pushed++;
         end
         @(negedge clk); #1;
         if (valid0 && out_ready) begin
            chk("rand_data_l0", data0, mem[ep0]);
            ep0 = ep0 + 8'd1;
         end
         if (valid1 && out_ready) begin
            chk("rand_data_l1", data1, mem[ep1]);
            ep1 = ep1 + 8'd1;
         end
         if ((rd0 && empty0) || (rd1 && empty1)) bad++;
         if (u_l0.count > 2'd2 || u_l1.count > 2'd2) bad++;
         cyc++;
      end
      chk("rand_violations", bad, 0);
      chk("rand_drained_l0", ep0, wp);
      chk("rand_drained_l1", ep1, wp);
      chk("rand_all_pushed", pushed, 200);

      // Reset with L1 at occ=2 and a read in flight
      idle(4);
      @(negedge clk);
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) push(8'hE0 + 8'(j));
      repeat (2) @(negedge clk);
      areset = 1'b1;
      wp = '0;
      #1;
      chk("t4_valid_l0", valid0, 0);
      chk("t4_data_l0",  data0,  0);
      chk("t4_rd_l0",    rd0,    0);
      chk("t4_valid_l1", valid1, 0);
      chk("t4_data_l1",  data1,  0);
      chk("t4_rd_l1",    rd1,    0);
      @(negedge clk);
      areset = 1'b0;
      push(8'h5A);
      push(8'h6B);
      out_ready = 1'b1;
      got0 = 8'hEE; got1 = 8'hEE;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (valid0 && got0 == 8'hEE) got0 = data0;
         if (valid1 && got1 == 8'hEE) got1 = data1;
         @(negedge clk);
      end
      chk("t4_first_beat_l0", got0, 8'h5A);
      chk("t4_first_beat_l1", got1, 8'h5A);

`ifdef STREAM_STATS_EN
      do_reset();
      @(negedge clk);
      for (int j = 0; j < 10; j++) push(8'h30 + 8'(j));
      for (int c = 0; c < 28; c++) begin
         out_ready = !(c >= 4 && c <= 7);
         @(negedge clk);
      end
      #1;
      chk("stats_beat_l0",  beat0,  10);
      chk("stats_stall_l0", stall0, 4);
      chk("stats_beat_l1",  beat1,  10);
      chk("stats_stall_l1", stall1, 4);
      out_ready = 1'b1;
      for (int c = 0; c < 70000; c++) begin
         push(8'(c));
         @(negedge clk);
      end
      idle(6);
      #1;
      chk("stats_sat_beat_l0",  beat0,  16'hFFFF);
      chk("stats_sat_beat_l1",  beat1,  16'hFFFF);
      chk("stats_sat_stall_l0", stall0, 4);
      chk("stats_sat_stall_l1", stall1, 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
